// File: rtl/conv_tile_loader_if.sv
// Pixel-stream in / tile-stream out handshake bundle for conv_tile_loader.
// pixel_sof exists only when CONV_TILE_LOADER_SOF_EN is defined.
interface conv_tile_loader_if #(
  parameter int PIX_W = 16
);
  logic [PIX_W-1:0]    pixel_in;
  logic                pixel_valid;
  logic                pixel_ready;
`ifdef CONV_TILE_LOADER_SOF_EN
  logic                pixel_sof;
`endif
  logic [36*PIX_W-1:0] tile_out;
  logic                tile_valid;
  logic                tile_ready;
  logic [7:0]          tile_x;
  logic [7:0]          tile_y;
  logic                frame_done;

  // master: the loader itself; slave: the surrounding pixel source / tile sink
  modport master (
`ifdef CONV_TILE_LOADER_SOF_EN
    input  pixel_sof,
`endif
    input  pixel_in, pixel_valid, tile_ready,
    output pixel_ready, tile_out, tile_valid, tile_x, tile_y, frame_done
  );

  modport slave (
`ifdef CONV_TILE_LOADER_SOF_EN
    output pixel_sof,
`endif
    output pixel_in, pixel_valid, tile_ready,
    input  pixel_ready, tile_out, tile_valid, tile_x, tile_y, frame_done
  );
endinterface

// File: rtl/conv_tile_loader.sv
// Buffers a 6-row band of a raster pixel stream and emits overlapping 6x6 tiles at stride 4; CONV_TILE_LOADER_SOF_EN adds pixel_sof restart.
// Latency: first tile the cycle after a band's last pixel; pixel_ready is low while tiles drain, tiles hold while tile_ready=0.
module conv_tile_loader #(
  parameter int IMG_W = 18,
  parameter int IMG_H = 18,
  parameter int PIX_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  conv_tile_loader_if.master  bus
);

  localparam int TILES_X = (IMG_W - 2) / 4;
  localparam int TILES_Y = (IMG_H - 2) / 4;
  localparam int CW      = $clog2(IMG_W);

  typedef enum logic {FILL, EMIT} state_t;

  state_t              state, state_n;
  logic [PIX_W-1:0]    band [6][IMG_W];
  logic [2:0]          wr_row;
  logic [CW-1:0]       wr_col;
  logic [7:0]          tile_x, tile_y;
  logic                pixel_ready_q;
  logic                frame_done_q;

  logic                pix_acc, sof, row_end, last_pix;
  logic                tile_hs, last_x, last_y, band_done;
  logic [2:0]          st_row;
  logic [CW-1:0]       st_col;
  logic [CW-1:0]       col_base;
  logic [36*PIX_W-1:0] tile_dat;

  always_comb begin
    state_n  = state;
    pix_acc  = bus.pixel_valid && pixel_ready_q;
`ifdef CONV_TILE_LOADER_SOF_EN
    sof      = pix_acc && bus.pixel_sof;
`else
    sof      = 1'b0;
`endif
    row_end  = (wr_col == CW'(IMG_W - 1));
    last_pix = pix_acc && !sof && row_end && (wr_row == 3'd5);
    tile_hs  = (state == EMIT) && bus.tile_ready;
    last_x   = (tile_x == 8'(TILES_X - 1));
    last_y   = (tile_y == 8'(TILES_Y - 1));
    band_done = tile_hs && last_x;
    // a start-of-frame beat always lands at (0,0) regardless of the fill pointer
    st_row   = sof ? 3'd0 : wr_row;
    st_col   = sof ? '0 : wr_col;
    case (state)
      FILL:    if (last_pix)  state_n = EMIT;
      EMIT:    if (band_done) state_n = FILL;
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      wr_row        <= 3'd0;
      wr_col        <= '0;
      tile_x        <= 8'd0;
      tile_y        <= 8'd0;
      pixel_ready_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state         <= state_n;
      pixel_ready_q <= (state_n == FILL);
      frame_done_q  <= band_done && last_y;
      if (pix_acc) begin
        if (sof) begin
          wr_row <= 3'd0;
          wr_col <= CW'(1);
          tile_x <= 8'd0;
          tile_y <= 8'd0;
        end else if (row_end) begin
          wr_col <= '0;
          wr_row <= (wr_row == 3'd5) ? 3'd0 : wr_row + 3'd1;
        end else begin
          wr_col <= wr_col + CW'(1);
        end
      end
      if (tile_hs) begin
        if (!last_x) begin
          tile_x <= tile_x + 8'd1;
        end else begin
          tile_x <= 8'd0;
          tile_y <= last_y ? 8'd0 : tile_y + 8'd1;
          // next band reuses the two overlap rows, so refill starts at row 2
          wr_row <= last_y ? 3'd0 : 3'd2;
        end
      end
    end
  end

  // band storage carries no reset: every location is rewritten before it is read
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      band[st_row][st_col] <= bus.pixel_in;
    end
    if (band_done && !last_y) begin
      for (int c = 0; c < IMG_W; c++) begin
        band[0][c] <= band[4][c];
        band[1][c] <= band[5][c];
      end
    end
  end

  always_comb begin
    col_base = CW'({tile_x, 2'b00});
    tile_dat = '0;
    if (state == EMIT) begin
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 6; c++) begin
          tile_dat[(r*6+c)*PIX_W +: PIX_W] = band[r][col_base + CW'(c)];
        end
      end
    end
  end

  assign bus.pixel_ready = pixel_ready_q;
  assign bus.tile_valid  = (state == EMIT);
  assign bus.tile_out    = tile_dat;
  assign bus.tile_x      = tile_x;
  assign bus.tile_y      = tile_y;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv_tile_loader.sv
// Scoreboard bench for conv_tile_loader on a 10x10 image: expected tiles are cut from the image array and queued.
module tb_conv_tile_loader;
  localparam int IMG_W = 10;
  localparam int IMG_H = 10;
  localparam int PIX_W = 16;
  localparam int TX    = (IMG_W - 2) / 4;
  localparam int TY    = (IMG_H - 2) / 4;
  localparam int TW    = 36 * PIX_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_tile_loader_if #(.PIX_W(PIX_W)) bus ();

  conv_tile_loader #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .PIX_W(PIX_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0]    x;
    logic [7:0]    y;
    logic [TW-1:0] t;
    bit            last;
  } exp_t;

  exp_t             sbq[$];
  logic [PIX_W-1:0] img [IMG_H][IMG_W];
  int  vectors     = 0;
  int  miscompares = 0;
  int  acc_cnt     = 0;
  int  fd_cnt      = 0;
  int  ready_mode  = 0;
  bit  fd_exp      = 1'b0;
  bit  prev_stall  = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tile(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Tile (tx,ty) is the 6x6 window of the image whose top-left corner is (4*ty, 4*tx).
  function automatic void push_frame();
    exp_t e;
    for (int ty = 0; ty < TY; ty++) begin
      for (int tx = 0; tx < TX; tx++) begin
        e.x    = 8'(tx);
        e.y    = 8'(ty);
        e.last = (tx == TX - 1) && (ty == TY - 1);
        e.t    = '0;
        for (int r = 0; r < 6; r++)
          for (int c = 0; c < 6; c++)
            e.t[(r*6+c)*PIX_W +: PIX_W] = img[4*ty+r][4*tx+c];
        sbq.push_back(e);
      end
    end
  endfunction

  task automatic send_pix(input logic [PIX_W-1:0] v, input bit sof, input bit gaps);
    int guard;
    guard = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.pixel_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.pixel_in    = v;
    bus.pixel_valid = 1'b1;
`ifdef CONV_TILE_LOADER_SOF_EN
    bus.pixel_sof   = sof;
`endif
    forever begin
      @(negedge clk);
      if (bus.pixel_ready) break;
      guard++;
      if (guard > 4000) begin
        $display("FAIL pixel_accept_timeout: pixel_ready low for %0d cycles, expected 1", guard);
        $fatal(1, "pixel stream stuck");
      end
    end
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
`ifdef CONV_TILE_LOADER_SOF_EN
    bus.pixel_sof   = 1'b0;
`endif
  endtask

  task automatic send_frame(input int base, input bit rnd, input bit gaps, input bit sof_first);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = rnd ? PIX_W'($urandom) : PIX_W'(base + r * 10 + c);
    push_frame();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        send_pix(img[r][c], sof_first && (r == 0) && (c == 0), gaps);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("tiles_drained", sbq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pixel_ready"}, bus.pixel_ready, 0);
    chk({tag, "_tile_valid"}, bus.tile_valid, 0);
    chk_tile({tag, "_tile_out"}, bus.tile_out, '0);
    chk({tag, "_tile_x"}, bus.tile_x, 0);
    chk({tag, "_tile_y"}, bus.tile_y, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      fd_exp     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (bus.pixel_valid && bus.pixel_ready) acc_cnt++;
      if (bus.frame_done) fd_cnt++;
      if (bus.frame_done || fd_exp) chk("frame_done_pulse", bus.frame_done, fd_exp);
      fd_exp = 1'b0;
      if (prev_stall) chk("tile_valid_held", bus.tile_valid, 1);
      prev_stall = bus.tile_valid && !bus.tile_ready;
      if (bus.tile_valid) begin
        chk("pixel_ready_in_emit", bus.pixel_ready, 0);
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tile: got tile x=%0d y=%0d, expected none", bus.tile_x, bus.tile_y);
        end else begin
          chk("tile_x", bus.tile_x, sbq[0].x);
          chk("tile_y", bus.tile_y, sbq[0].y);
          chk_tile("tile_out", bus.tile_out, sbq[0].t);
          if (bus.tile_ready) begin
            fd_exp = sbq[0].last;
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  // Downstream: 0 = always ready, 1 = five-plus stall cycles per tile, 2 = random
  initial begin
    int stall_cnt;
    stall_cnt      = 0;
    bus.tile_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.tile_ready = 1'b1;
        1: begin
          if (bus.tile_ready) begin
            bus.tile_ready = 1'b0;
            stall_cnt      = 0;
          end else if (bus.tile_valid) begin
            stall_cnt++;
            if (stall_cnt >= 6) bus.tile_ready = 1'b1;
          end
        end
        default: bus.tile_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, a0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = '0;
`ifdef CONV_TILE_LOADER_SOF_EN
    bus.pixel_sof   = 1'b0;
`endif
    #2;
    check_reset("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // plain frame, always ready
    ready_mode = 0;
    fd0 = fd_cnt;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("frame_done_count_single", fd_cnt - fd0, 1);

    // same frame with downstream stalls
    ready_mode = 1;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    drain();

    // random upstream gaps
    ready_mode = 0;
    a0 = acc_cnt;
    send_frame(0, 1'b0, 1'b1, 1'b0);
    drain();
    chk("accepted_beats", acc_cnt - a0, 100);

    // two frames back to back
    fd0 = fd_cnt;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    send_frame(1000, 1'b0, 1'b0, 1'b0);
    drain();
    chk("frame_done_count_double", fd_cnt - fd0, 2);

    // reset in the middle of a band
    for (int i = 0; i < 37; i++) send_pix(PIX_W'($urandom), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset("async");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    drain();

`ifdef CONV_TILE_LOADER_SOF_EN
    // partial frame abandoned by a start-of-frame beat
    for (int i = 0; i < 20; i++) send_pix(PIX_W'($urandom), 1'b0, 1'b0);
    send_frame(0, 1'b0, 1'b0, 1'b1);
    drain();
`endif

    // random pixels, random gaps, random downstream readiness
    ready_mode = 2;
    send_frame(0, 1'b1, 1'b1, 1'b0);
    send_frame(0, 1'b1, 1'b1, 1'b0);
    drain();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_tile_loader.md
Name: conv_tile_loader

Overview:
- Upstream feeder for the 4x4 convolution tile engine.
- Accepts a raster-order pixel stream (one 16-bit pixel per beat), buffers a 6-row band and emits overlapping 6x6 tiles (36 x 16 bit, row-major).
- Tile stride is 4 in both dimensions, so every tile yields exactly 16 valid 3x3 outputs downstream.
- Tiles are emitted left-to-right, then band by band top-to-bottom, with a valid/ready handshake on both sides.

Parameters:
- IMG_W, 18, image width in pixels; (IMG_W-2) must be a multiple of 4.
- IMG_H, 18, image height in pixels; (IMG_H-2) must be a multiple of 4.
- PIX_W, 16, pixel width in bits.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pixel_in  in  PIX_W  input pixel, raster order
- pixel_valid  in  1  pixel_in valid
- pixel_ready  out  1  loader accepts pixel this cycle
- tile_out  out  36*PIX_W  6x6 tile; element k = r*6+c at bits [k*PIX_W +: PIX_W]
- tile_valid  out  1  tile_out valid
- tile_ready  in  1  downstream accepts tile
- tile_x  out  8  tile column index, 0..TILES_X-1
- tile_y  out  8  tile row (band) index, 0..TILES_Y-1
- frame_done  out  1  one-cycle pulse after last tile of frame accepted

Behaviour:
- TILES_X = (IMG_W-2)/4; TILES_Y = (IMG_H-2)/4. Band storage is 6 x IMG_W registers.
- Reset (async, rst_n=0): FSM=FILL, row/col/tile counters=0, band_first=1.
  - Outputs: pixel_ready=0 during reset, tile_valid=0, tile_out=0, tile_x=0, tile_y=0, frame_done=0.
- Pixel acceptance: a beat is accepted when pixel_valid && pixel_ready.
- FILL state: pixel_ready=1. Accepted pixels are written to band row wr_row, column wr_col, and wr_col increments.
  - At IMG_W-1, wr_col wraps to 0 and wr_row increments.
  - band_first=1: fill rows 0..5 (6*IMG_W pixels).
  - band_first=0: rows 0,1 already hold the previous band's rows 4,5; fill rows 2..5 (4*IMG_W pixels).
- Acceptance of the last pixel of a band -> next cycle FSM=EMIT, tile_out = band columns 0..5, tile_valid=1, tile_x=0.
- EMIT state: pixel_ready=0.
  - tile_out, tile_x and tile_y are held stable while tile_valid && !tile_ready.
  - On handshake with tile_x < TILES_X-1: the next tile loads the following cycle (columns 4*tile_x' .. 4*tile_x'+5) and tile_valid stays 1. Back-to-back tiles are permitted, one per cycle.
  - On handshake of the last tile of a band that is not the last band:
    - tile_valid=0 next cycle.
    - Rows 4,5 are copied to rows 0,1.
    - band_first=0, tile_y increments, FSM=FILL with wr_row=2.
    - pixel_ready=1 on that cycle.
  - On handshake of the last tile of the frame:
    - frame_done=1 for exactly the next cycle.
    - tile_valid=0, FSM=FILL, band_first=1, tile_y=0, tile_x=0.
    - Next pixel is treated as image (0,0).
- Pixels are never dropped or duplicated. pixel_valid while pixel_ready=0 is held by upstream.
- Data is copied bit-exactly; no arithmetic is performed on pixel values.
- tile_valid never drops without a handshake, except on reset.
- Reset mid-frame discards the partial band and any pending tile. The frame restarts from (0,0).

Optional Feature:
- Macro: CONV_TILE_LOADER_SOF_EN.
- Defined:
  - Adds input port pixel_sof (1 bit).
  - An accepted beat with pixel_sof=1 aborts the current frame: counters are cleared, band_first=1, and that pixel is stored as (0,0).
  - pixel_ready stays 0 in EMIT, so SOF only takes effect in FILL.
- Not defined: no pixel_sof port. Frame boundaries are implied purely by pixel count.

Test Plan:
- IMG_W=IMG_H=10, pixel(r,c)=r*10+c streamed, tile_ready=1. Expect 4 tiles in order (0,0),(1,0),(0,1),(1,1) as (tile_x,tile_y).
  - Tile(0,0): element0=0, element35=55.
  - Tile(1,0): element0=4, element35=59.
  - Tile(0,1): element0=40, element35=95.
  - Tile(1,1): element35=99.
  - frame_done pulses once.
- Same frame with tile_ready=0 for 5 cycles on each tile. tile_out, tile_x and tile_y stay constant while stalled; pixel_ready=0 throughout EMIT; no data change.
- Random pixel_valid gaps (50% duty). Tile contents identical to the first test; total accepted beats=100.
- Two frames back-to-back, the second with pixel=1000+r*10+c. Second frame tile(0,0) element0=1000. frame_done pulses twice.
- rst_n low after 37 pixels, then a full frame. Outputs return to reset values asynchronously; the subsequent frame matches the first test exactly.
- With CONV_TILE_LOADER_SOF_EN: 20 pixels, then SOF on a pixel of value 0 followed by the first test's frame. Output tiles match the first test.
